// File: rtl/ctrl_pkg.sv
// Shared controller types: done-handshake FSM states, the dimension type
// used by the compute and done-delay stages, and a lane-width helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } done_state_t;

  typedef logic [15:0] dim_t;

  // Shift amount that divides by the lane count (lanes is a power of two).
  function automatic int unsigned lanes_log2(input int unsigned lanes);
    return (lanes <= 1) ? 0 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled counter that wraps back to zero after reaching limit, with a
// one-cycle wrap strobe. With HOLD_ON_WRAP set it steps to limit+1 instead
// of zero, so a terminal count stays readable after the final wrap.
module wrap_counter #(
  parameter int unsigned W            = 8,
  parameter bit          HOLD_ON_WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = en && !clr && (cnt_q == limit);
  assign cnt  = cnt_q;

  // Next count: clear dominates, then wrap, then plain increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = HOLD_ON_WRAP ? cnt_q + 1'b1 : '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/compute_done_gen.sv
// Producer side of the layer done_compute handshake: counts PE-array output
// beats per pixel and pixels per layer, raises done_compute after the last
// beat of the layer and holds it until done_ack. Also registers the drain
// length for the downstream done-delay stage.
module compute_done_gen
  import ctrl_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  dim_t             IFM_C,
  input  dim_t             OFM_W,
  input  dim_t             OFM_H,
  input  dim_t             OFM_C,
  input  logic             ofm_valid,
  input  logic             done_ack,
  output logic             busy,
  output logic             done_compute,
  output logic [CNT_W-1:0] drain_len,
  output logic [CNT_W-1:0] px_cnt,
  output logic             err_overrun
);

  localparam int unsigned LANES_LOG2 = lanes_log2(LANES);
  localparam int unsigned CH_W       = 17;

  done_state_t      state_q;
  dim_t             ofm_w_q;
  dim_t             ofm_h_q;
  dim_t             ofm_c_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] drain_q;

  logic             start_acc;
  logic             zero_size;
  logic [31:0]      drain_prod;
  logic [CH_W-1:0]  beats_per_px;
  logic [CH_W-1:0]  ch_limit;
  logic [31:0]      total_px;
  logic [CNT_W-1:0] px_limit;
  logic             ch_en;
  logic [CH_W-1:0]  ch_cnt;
  logic             ch_wrap;
  logic             px_wrap;

  assign start_acc  = (state_q == IDLE) && start;
  assign zero_size  = (OFM_W == '0) || (OFM_H == '0) || (OFM_C == '0);
  assign drain_prod = {16'b0, IFM_C} * {16'b0, OFM_C};

  // Geometry is derived from the latched dimensions so it stays fixed for
  // the whole layer regardless of what the inputs do after start.
  assign beats_per_px = ({1'b0, ofm_c_q} + CH_W'(LANES - 1)) >> LANES_LOG2;
  assign ch_limit     = beats_per_px - 1'b1;
  assign total_px     = {16'b0, ofm_w_q} * {16'b0, ofm_h_q};
  assign px_limit     = CNT_W'(total_px - 32'd1);

  assign ch_en = (state_q == RUN) && ofm_valid;

  wrap_counter #(
    .W            (CH_W),
    .HOLD_ON_WRAP (1'b0)
  ) u_ch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ch_en),
    .clr   (start_acc),
    .limit (ch_limit),
    .cnt   (ch_cnt),
    .wrap  (ch_wrap)
  );

  // Pixel counter steps past its limit on the final wrap so px_cnt reads
  // total_px in DONE; leaving RUN on that same edge stops any further count.
  wrap_counter #(
    .W            (CNT_W),
    .HOLD_ON_WRAP (1'b1)
  ) u_px_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ch_wrap),
    .clr   (start_acc),
    .limit (px_limit),
    .cnt   (px_cnt),
    .wrap  (px_wrap)
  );

  // Layer FSM with registered busy/done, dimension latches, drain length and
  // the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ofm_w_q <= '0;
      ofm_h_q <= '0;
      ofm_c_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ofm_w_q <= OFM_W;
            ofm_h_q <= OFM_H;
            ofm_c_q <= OFM_C;
            drain_q <= CNT_W'(drain_prod >> 2);
            busy_q  <= 1'b1;
            // A beat coincident with start is dropped but still flagged,
            // overriding the clear that start otherwise performs.
            err_q   <= ofm_valid;
            if (zero_size) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              done_q  <= 1'b0;
            end
          end else if (ofm_valid) begin
            err_q <= 1'b1;
          end
        end
        RUN: begin
          if (px_wrap) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (ofm_valid) begin
            err_q <= 1'b1;
          end
          if (done_ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done_compute = done_q;
  assign drain_len    = drain_q;
  assign err_overrun  = err_q;

endmodule

// File: tb/tb_compute_done_gen.sv
module tb_compute_done_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] IFM_C, OFM_W, OFM_H, OFM_C;
  logic        ofm_valid;
  logic        done_ack;
  logic        busy;
  logic        done_compute;
  logic [31:0] drain_len;
  logic [31:0] px_cnt;
  logic        err_overrun;

  compute_done_gen #(
    .LANES (4),
    .CNT_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .IFM_C        (IFM_C),
    .OFM_W        (OFM_W),
    .OFM_H        (OFM_H),
    .OFM_C        (OFM_C),
    .ofm_valid    (ofm_valid),
    .done_ack     (done_ack),
    .busy         (busy),
    .done_compute (done_compute),
    .drain_len    (drain_len),
    .px_cnt       (px_cnt),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned px;
    int unsigned drain;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every rising done_compute is matched against the next queued
  // expectation (final pixel count, drain length, cycle of the rise).
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_compute && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_px_cnt", px_cnt, e.px);
        chk("done_drain_len", drain_len, e.drain);
        chk("done_rise_cycle", cyc, e.cyc);
      end
    end
    done_prev <= done_compute;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned px, input int unsigned drain);
    exp_t e;
    e.px = px; e.drain = drain; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic set_dims(input logic [15:0] ic, input logic [15:0] w,
                          input logic [15:0] h, input logic [15:0] oc);
    IFM_C = ic; OFM_W = w; OFM_H = h; OFM_C = oc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ofm_valid = 1'b0; done_ack = 1'b0;
    set_dims(16'd0, 16'd0, 16'd0, 16'd0);
    #1;
    repeat (3) tick();
    rst = 1'b0;
    chk("por_busy", busy, 0);
    chk("por_done", done_compute, 0);
    chk("por_px", px_cnt, 0);
    chk("por_drain", drain_len, 0);
    chk("por_err", err_overrun, 0);

    // Mid-RUN reset: start a layer, send a few beats, then reset 3 cycles.
    set_dims(16'd8, 16'd2, 16'd2, 16'd8);
    start = 1'b1; tick(); start = 1'b0;
    ofm_valid = 1'b1; repeat (3) tick(); ofm_valid = 1'b0;
    chk("pre_rst_px", px_cnt, 1);
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_compute, 0);
    chk("rst_px", px_cnt, 0);
    chk("rst_drain", drain_len, 0);
    chk("rst_err", err_overrun, 0);

    // Nominal: 8 channels over 4 lanes -> 2 beats/pixel, 4 pixels, 8 beats.
    set_dims(16'd8, 16'd2, 16'd2, 16'd8);
    start = 1'b1; tick(); start = 1'b0;
    chk("nom_busy", busy, 1);
    chk("nom_drain", drain_len, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk("nom_mid_px", px_cnt, 2);
      chk("nom_not_done", done_compute, 0);
      ofm_valid = 1'b1;
      if (i == 7) push_exp(4, 16);
      tick();
    end
    ofm_valid = 1'b0;

    // Handshake: ack held off 10 cycles, start pulsed during DONE ignored.
    set_dims(16'd40, 16'd9, 16'd9, 16'd100);
    for (int k = 0; k < 10; k++) begin
      chk("hold_done", done_compute, 1);
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    chk("hold_busy", busy, 1);
    chk("hold_drain", drain_len, 16);
    chk("hold_px", px_cnt, 4);
    done_ack = 1'b1; tick(); done_ack = 1'b0;
    chk("ack_done_low", done_compute, 0);
    chk("ack_busy_low", busy, 0);
    chk("idle_px_hold", px_cnt, 4);

    // Non-multiple channel count: 5 channels -> 2 beats, gapped 1,0,0,1.
    set_dims(16'd4, 16'd1, 16'd1, 16'd5);
    start = 1'b1; tick(); start = 1'b0;
    chk("nm_drain", drain_len, 5);
    ofm_valid = 1'b1; tick(); ofm_valid = 1'b0;
    chk("nm_after_b1_done", done_compute, 0);
    chk("nm_after_b1_px", px_cnt, 0);
    tick(); tick();
    chk("nm_gap_done", done_compute, 0);
    ofm_valid = 1'b1; push_exp(1, 5); tick(); ofm_valid = 1'b0;
    chk("nm_done", done_compute, 1);
    done_ack = 1'b1; tick(); done_ack = 1'b0;

    // Zero-size layer: OFM_H=0 goes straight to DONE.
    set_dims(16'd16, 16'd3, 16'd0, 16'd4);
    start = 1'b1; push_exp(0, 16); tick(); start = 1'b0;
    chk("zero_done", done_compute, 1);
    chk("zero_px", px_cnt, 0);

    // Overrun during DONE; start and ack together (ack wins, start dropped).
    ofm_valid = 1'b1; tick(); ofm_valid = 1'b0;
    chk("ovr_err", err_overrun, 1);
    chk("ovr_px", px_cnt, 0);
    set_dims(16'd2, 16'd5, 16'd5, 16'd4);
    start = 1'b1; done_ack = 1'b1; tick(); start = 1'b0; done_ack = 1'b0;
    chk("ack_start_busy", busy, 0);
    chk("ack_start_drain", drain_len, 16);
    chk("ovr_err_sticky", err_overrun, 1);

    // Start with coincident beat: layer starts, beat dropped, error set.
    set_dims(16'd8, 16'd1, 16'd1, 16'd4);
    start = 1'b1; ofm_valid = 1'b1; tick(); start = 1'b0; ofm_valid = 1'b0;
    chk("sv_busy", busy, 1);
    chk("sv_err", err_overrun, 1);
    chk("sv_px", px_cnt, 0);
    chk("sv_done", done_compute, 0);
    ofm_valid = 1'b1; push_exp(1, 8); tick(); ofm_valid = 1'b0;
    done_ack = 1'b1; tick(); done_ack = 1'b0;

    // Clean start clears the sticky error.
    set_dims(16'd1, 16'd1, 16'd1, 16'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_err", err_overrun, 0);
    ofm_valid = 1'b1; push_exp(1, 0); tick(); ofm_valid = 1'b0;
    done_ack = 1'b1; tick(); done_ack = 1'b0;
    tick(); tick();

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
